blkdev_ctrl: RTL and testbench

Double-buffered block-device controller on the PI1 bus, directly downstream of the boot loader. Slave port implements the block-device command set (status/reset, read, swap, write) with RW-op commands, plus word access to a front block buffer. Drives a block-level handshake toward the storage PHY (SD/SPI engine), which moves whole blocks in and out of the back buffer. A swap exchanges front and back buffers in one cycle.

---
 rtl/blkdev_ctrl_pkg.sv | 33 +++
 rtl/blkdev_ctrl_bufram.sv | 52 +++++
 rtl/blkdev_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_blkdev_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blkdev_ctrl_pkg.sv
// Shared codes for the PI1 block-device controller: bus ops, status and command codes, FSM states.
package blkdev_ctrl_pkg;

    localparam logic [1:0] OP_NOOP = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_RW   = 2'b11;

    localparam logic [1:0] STAT_POWEROFF = 2'd0;
    localparam logic [1:0] STAT_READY    = 2'd1;
    localparam logic [1:0] STAT_BUSY     = 2'd2;
    localparam logic [1:0] STAT_ERROR    = 2'd3;

    localparam int unsigned CMD_RESET = 0;
    localparam int unsigned CMD_SWAP  = 1;
    localparam int unsigned CMD_READ  = 2;
    localparam int unsigned CMD_WRITE = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    // Status priority: power, then sticky error, then activity.
    function automatic logic [1:0] status_of(input logic phy_ready, input logic err, input logic busy);
        if (!phy_ready)  return STAT_POWEROFF;
        else if (err)    return STAT_ERROR;
        else if (busy)   return STAT_BUSY;
        else             return STAT_READY;
    endfunction

endpackage

// File: rtl/blkdev_ctrl_bufram.sv
// Dual-port block buffer RAM: port A byte-enabled bus side, port B PHY side; registered reads.
// Port B read path exists only with BLKDEV_CTRL_WRITE_EN.
module blkdev_ctrl_bufram #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW/8-1:0] a_be_i,
    input  logic [DW-1:0] a_wdata_i,
    input  logic          a_re_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    input  logic          b_we_i,
    input  logic [DW-1:0] b_wdata_i
`ifdef BLKDEV_CTRL_WRITE_EN
    ,
    output logic [DW-1:0] b_rdata_o
`endif
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_qa;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DW/8; i++) begin
            if (a_be_i[i]) r_mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
        end
        if (b_we_i) r_mem[b_addr_i] <= b_wdata_i;
    end

    // Read register holds its value between reads so bus read data stays stable.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)      r_qa <= '0;
        else if (a_re_i) r_qa <= r_mem[a_addr_i];
    end

    assign a_rdata_o = r_qa;

`ifdef BLKDEV_CTRL_WRITE_EN
    logic [DW-1:0] r_qb;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_qb <= '0;
        else        r_qb <= r_mem[b_addr_i];
    end

    assign b_rdata_o = r_qb;
`endif

endmodule

// File: rtl/blkdev_ctrl.sv
// Double-buffered block-device controller: PI1 slave with front-buffer access and block commands,
// block handshake to the storage PHY. Block writes are built only with BLKDEV_CTRL_WRITE_EN.
module blkdev_ctrl
    import blkdev_ctrl_pkg::*;
#(
    parameter int ARCHBITSZ = 32,
    parameter int BLKSZ     = 512,
    parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             s_pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   s_pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   s_pi1_data_i,
    output logic [ARCHBITSZ-1:0]   s_pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] s_pi1_sel_i,
    output logic                   s_pi1_rdy_o,
    input  logic                   phy_ready_i,
    output logic                   blk_req_o,
    input  logic                   blk_ack_i,
    output logic                   blk_wr_o,
    output logic [ARCHBITSZ-1:0]   blk_addr_o,
    input  logic [ARCHBITSZ-1:0]   blk_rdata_i,
    input  logic                   blk_rvalid_i,
    output logic [ARCHBITSZ-1:0]   blk_wdata_o,
    output logic                   blk_wvalid_o,
    input  logic                   blk_wready_i,
    input  logic                   blk_done_i,
    input  logic                   blk_err_i,
    output state_e                 dbg_state_o
);

    localparam int SELW     = ARCHBITSZ/8;
    localparam int BLKWORDS = BLKSZ/SELW;
    localparam int IDXW     = $clog2(BLKWORDS);
    localparam int CNTW     = IDXW + 1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(BLKWORDS);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_rdy;
    logic                   r_bank;
    logic                   r_err;
    logic                   r_wr;
    logic                   r_src_ram;
    logic [1:0]             r_stat;
    logic [CNTW-1:0]        r_cnt;
    logic [CNTW-1:0]        w_cnt_nxt;
    logic [ARCHBITSZ-1:0]   r_blk_addr;
    logic [ARCHBITSZ-1:0]   w_qa;
    logic [1:0]             w_status;
    logic                   w_acc;
    logic                   w_rw;
    logic                   w_ready;
    logic                   w_cmd_reset;
    logic                   w_cmd_swap;
    logic                   w_cmd_read;
    logic                   w_cmd_write;
    logic                   w_cnt_lt;
    logic                   w_wbeat;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_err_set;
    logic                   w_b_we;
    logic [IDXW:0]          w_a_addr;
    logic [IDXW:0]          w_b_addr;
    logic [SELW-1:0]        w_a_be;
    logic                   w_a_re;

    // Bus handshake: a request is taken on any cycle with op != NOOP while rdy is high;
    // there are no wait states, so rdy only drops during reset.
    assign w_acc    = r_rdy && (s_pi1_op_i != OP_NOOP);
    assign w_rw     = w_acc && (s_pi1_op_i == OP_RW);
    assign w_status = status_of(phy_ready_i, r_err, r_state != ST_IDLE);
    assign w_ready  = (w_status == STAT_READY);

    assign w_cmd_reset = w_rw && (s_pi1_addr_i == ADDRBITSZ'(CMD_RESET))
                              && (s_pi1_data_i == ARCHBITSZ'(1));
    assign w_cmd_swap  = w_rw && w_ready && (s_pi1_addr_i == ADDRBITSZ'(CMD_SWAP));
    assign w_cmd_read  = w_rw && w_ready && (s_pi1_addr_i == ADDRBITSZ'(CMD_READ));
    assign w_cnt_lt    = (r_cnt < CNT_FULL);

`ifdef BLKDEV_CTRL_WRITE_EN
    logic                 w_wvalid;
    logic [ARCHBITSZ-1:0] w_qb;

    assign w_cmd_write  = w_rw && w_ready && (s_pi1_addr_i == ADDRBITSZ'(CMD_WRITE));
    assign w_wvalid     = r_wr && (r_state == ST_XFER) && w_cnt_lt;
    assign w_wbeat      = w_wvalid && blk_wready_i;
    assign blk_wr_o     = r_wr;
    assign blk_wvalid_o = w_wvalid;
    assign blk_wdata_o  = w_qb;
`else
    logic w_unused;

    assign w_cmd_write  = 1'b0;
    assign w_wbeat      = 1'b0;
    assign blk_wr_o     = 1'b0;
    assign blk_wvalid_o = 1'b0;
    assign blk_wdata_o  = '0;
    assign w_unused     = blk_wready_i;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A RESET command overrides every PHY event in the same cycle; blk_err_i beats blk_done_i.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_err_set   = 1'b0;
        w_b_we      = 1'b0;
        if (w_cmd_reset) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_read || w_cmd_write) w_state_nxt = ST_REQ;
                end
                ST_REQ: begin
                    if (blk_err_i) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (!phy_ready_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (blk_ack_i) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (blk_err_i) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (!phy_ready_i) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        if (r_wr) begin
                            w_cnt_inc = w_wbeat;
                        end else if (blk_rvalid_i && w_cnt_lt) begin
                            w_cnt_inc = 1'b1;
                            w_b_we    = 1'b1;
                        end
                        if (blk_done_i) begin
                            w_state_nxt = ST_IDLE;
                            if (r_cnt != CNT_FULL) w_err_set = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_cnt_nxt = w_cnt_clr ? '0 : (r_cnt + CNTW'(w_cnt_inc));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdy      <= 1'b0;
            r_bank     <= 1'b0;
            r_err      <= 1'b0;
            r_wr       <= 1'b0;
            r_cnt      <= '0;
            r_blk_addr <= '0;
            r_stat     <= STAT_POWEROFF;
            r_src_ram  <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            r_cnt <= w_cnt_nxt;
            if (w_cmd_reset) begin
                r_err  <= 1'b0;
                r_bank <= 1'b0;
            end else begin
                if (w_err_set)  r_err  <= 1'b1;
                if (w_cmd_swap) r_bank <= ~r_bank;
            end
            if (w_cmd_read || w_cmd_write) begin
                r_blk_addr <= s_pi1_data_i;
                r_wr       <= w_cmd_write;
            end
            // data_o source selects between the RAM read register and the captured status.
            if (w_rw) begin
                r_stat    <= w_status;
                r_src_ram <= 1'b0;
            end else if (w_acc && (s_pi1_op_i == OP_RD)) begin
                r_src_ram <= 1'b1;
            end
        end
    end

    assign w_a_addr = {r_bank, s_pi1_addr_i[IDXW-1:0]};
    assign w_a_be   = (w_acc && (s_pi1_op_i == OP_WR)) ? s_pi1_sel_i : '0;
    assign w_a_re   = w_acc && (s_pi1_op_i == OP_RD);
    // Write streaming reads one word ahead so wdata already holds the word at the counter.
    assign w_b_addr = {~r_bank, r_wr ? w_cnt_nxt[IDXW-1:0] : r_cnt[IDXW-1:0]};

    blkdev_ctrl_bufram #(
        .DW (ARCHBITSZ),
        .AW (IDXW + 1)
    ) u_bufram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_addr_i  (w_a_addr),
        .a_be_i    (w_a_be),
        .a_wdata_i (s_pi1_data_i),
        .a_re_i    (w_a_re),
        .a_rdata_o (w_qa),
        .b_addr_i  (w_b_addr),
        .b_we_i    (w_b_we),
        .b_wdata_i (blk_rdata_i)
`ifdef BLKDEV_CTRL_WRITE_EN
        ,
        .b_rdata_o (w_qb)
`endif
    );

    assign s_pi1_data_o = r_src_ram ? w_qa : {{(ARCHBITSZ-2){1'b0}}, r_stat};
    assign s_pi1_rdy_o  = r_rdy;
    assign blk_req_o    = (r_state == ST_REQ);
    assign blk_addr_o   = r_blk_addr;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_blkdev_ctrl.sv
// Self-checking bench for blkdev_ctrl: vector table, directed block sequences, random traffic vs buffer model.
`timescale 1ns/1ps
module tb_blkdev_ctrl;
    import blkdev_ctrl_pkg::*;

    localparam int BLKW = 128;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  s_op = OP_NOOP;
    logic [29:0] s_addr = '0;
    logic [31:0] s_data = '0;
    logic [31:0] s_data_o;
    logic [3:0]  s_sel = '0;
    logic        s_rdy;
    logic        phy_ready = 1'b1;
    logic        blk_req, blk_ack = 1'b0, blk_wr;
    logic [31:0] blk_addr, blk_rdata = '0, blk_wdata;
    logic        blk_rvalid = 1'b0, blk_wvalid, blk_wready = 1'b0;
    logic        blk_done = 1'b0, blk_err = 1'b0;
    state_e      dbg_state;

    blkdev_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_pi1_op_i(s_op), .s_pi1_addr_i(s_addr), .s_pi1_data_i(s_data),
        .s_pi1_data_o(s_data_o), .s_pi1_sel_i(s_sel), .s_pi1_rdy_o(s_rdy),
        .phy_ready_i(phy_ready), .blk_req_o(blk_req), .blk_ack_i(blk_ack),
        .blk_wr_o(blk_wr), .blk_addr_o(blk_addr), .blk_rdata_i(blk_rdata),
        .blk_rvalid_i(blk_rvalid), .blk_wdata_o(blk_wdata), .blk_wvalid_o(blk_wvalid),
        .blk_wready_i(blk_wready), .blk_done_i(blk_done), .blk_err_i(blk_err),
        .dbg_state_o(dbg_state)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] mem_m [0:1][0:BLKW-1];
    logic        bank_m = 1'b0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d, input logic [3:0] sel);
        s_op = op; s_addr = a; s_data = d; s_sel = sel;
        tick;
        s_op = OP_NOOP;
    endtask

    task automatic rw(input logic [29:0] a, input logic [31:0] d);
        bus(OP_RW, a, d, 4'h0);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] sel);
        bus(OP_WR, a, d, sel);
        for (int b = 0; b < 4; b++)
            if (sel[b]) mem_m[bank_m][a[6:0]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic rd_model(input string name, input logic [29:0] a);
        bus(OP_RD, a, 32'h0, 4'h0);
        chk(name, s_data_o, mem_m[bank_m][a[6:0]]);
    endtask

    task automatic status_chk(input string name, input logic [31:0] exp);
        rw(30'd0, 32'd0);
        chk(name, s_data_o, exp);
    endtask

    task automatic start_read(input logic [31:0] blk, input string tag);
        int dly;
        rw(30'(CMD_READ), blk);
        chk({tag, " cmd status"}, s_data_o, 32'd1);
        chk({tag, " req"}, {31'b0, blk_req}, 32'd1);
        chk({tag, " blk_addr"}, blk_addr, blk);
        chk({tag, " blk_wr"}, {31'b0, blk_wr}, 32'd0);
        dly = $urandom_range(0, 2);
        repeat (dly) begin
            tick;
            chk({tag, " req held"}, {31'b0, blk_req}, 32'd1);
        end
        blk_ack = 1'b1;
        tick;
        blk_ack = 1'b0;
        chk({tag, " req drop"}, {31'b0, blk_req}, 32'd0);
    endtask

    task automatic stream(input int n, input bit gaps, input bit rnd, input logic [31:0] base);
        int i;
        logic [31:0] d;
        i = 0;
        while (i < n) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                blk_rvalid = 1'b0;
            end else begin
                d = rnd ? $urandom : base + 32'(i);
                blk_rvalid = 1'b1;
                blk_rdata  = d;
                if (i < BLKW) mem_m[!bank_m][i] = d;
                i++;
            end
            tick;
        end
        blk_rvalid = 1'b0;
    endtask

    task automatic pulse_done;
        blk_done = 1'b1;
        tick;
        blk_done = 1'b0;
    endtask

    task automatic fill_front;
        for (int i = 0; i < BLKW; i++) wr(30'(i), $urandom, 4'hF);
    endtask

    initial begin
        vecs[0]  = '{OP_WR, 30'd3,          32'h0,        4'hF, 1'b0, 32'h0};
        vecs[1]  = '{OP_WR, 30'd3,          32'hAABBCCDD, 4'h4, 1'b0, 32'h0};
        vecs[2]  = '{OP_RD, 30'd3,          32'h0,        4'h0, 1'b1, 32'h00BB0000};
        vecs[3]  = '{OP_WR, 30'd6,          32'h1,        4'hF, 1'b1, 32'h00BB0000};
        vecs[4]  = '{OP_RW, 30'd0,          32'h0,        4'h0, 1'b1, 32'h1};
        vecs[5]  = '{OP_WR, 30'd130,        32'h12345678, 4'hF, 1'b0, 32'h0};
        vecs[6]  = '{OP_RD, 30'd2,          32'h0,        4'h0, 1'b1, 32'h12345678};
        vecs[7]  = '{OP_RW, 30'd1,          32'h0,        4'h0, 1'b1, 32'h1};
        vecs[8]  = '{OP_WR, 30'd3,          32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{OP_RD, 30'd3,          32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{OP_RD, 30'h0010_0003,  32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
        vecs[11] = '{OP_RW, 30'd1,          32'h0,        4'h0, 1'b1, 32'h1};
        vecs[12] = '{OP_RD, 30'd3,          32'h0,        4'h0, 1'b1, 32'h00BB0000};
        vecs[13] = '{OP_RW, 30'd5,          32'h0,        4'h0, 1'b1, 32'h1};
        vecs[14] = '{OP_WR, 30'd4,          32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        vecs[15] = '{OP_WR, 30'd4,          32'h11223344, 4'h9, 1'b0, 32'h0};
        vecs[16] = '{OP_RD, 30'd4,          32'h0,        4'h0, 1'b1, 32'h11FFFF44};
        vecs[17] = '{OP_RW, 30'd0,          32'h2,        4'h0, 1'b1, 32'h1};

        // Reset values and release
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst rdy", {31'b0, s_rdy}, 32'd0);
        chk("rst data_o", s_data_o, 32'd0);
        chk("rst req", {31'b0, blk_req}, 32'd0);
        chk("rst wvalid", {31'b0, blk_wvalid}, 32'd0);
        chk("rst wdata", blk_wdata, 32'd0);
        rst_i = 1'b1;
        chk("rdy before edge", {31'b0, s_rdy}, 32'd0);
        tick;
        chk("rdy after release", {31'b0, s_rdy}, 32'd1);

        status_chk("status ready", 32'd1);
        phy_ready = 1'b0;
        status_chk("status poweroff", 32'd0);
        phy_ready = 1'b1;

        // Vector table: back-to-back bus accesses, one per cycle
        for (int i = 0; i < 18; i++) begin
            s_op = vecs[i].op; s_addr = vecs[i].addr; s_data = vecs[i].data; s_sel = vecs[i].sel;
            tick;
            if (vecs[i].chk) chk($sformatf("vec%0d", i), s_data_o, vecs[i].exp);
        end
        s_op = OP_NOOP;

        // Full block read of words 0..127 into bank 1
        start_read(32'd5, "B");
        status_chk("B busy req/xfer", 32'd2);
        stream(BLKW, 1'b0, 1'b0, 32'd0);
        status_chk("B busy before done", 32'd2);
        pulse_done;
        status_chk("B ready after done", 32'd1);
        rw(30'(CMD_SWAP), 32'd0);
        chk("B swap status", s_data_o, 32'd1);
        bank_m = ~bank_m;
        bus(OP_RD, 30'd7, 32'd0, 4'h0);
        chk("B rd7 after swap", s_data_o, 32'd7);

        // Short block: done after 100 words sets ERROR
        start_read(32'd6, "C");
        stream(100, 1'b0, 1'b0, 32'd1000);
        pulse_done;
        status_chk("C short error", 32'd3);
        rw(30'(CMD_SWAP), 32'd0);
        chk("C swap ignored status", s_data_o, 32'd3);
        bus(OP_RD, 30'd7, 32'd0, 4'h0);
        chk("C rd7 old bank", s_data_o, 32'd7);
        rw(30'd0, 32'd1);
        chk("C reset returns prior", s_data_o, 32'd3);
        bank_m = 1'b0;
        status_chk("C ready after reset", 32'd1);
        bus(OP_RD, 30'd7, 32'd0, 4'h0);
        chk("C rd7 bank0 after reset", s_data_o, 32'd1007);

        // Error pulse together with done: error wins
        start_read(32'd8, "D");
        stream(5, 1'b0, 1'b1, 32'd0);
        blk_err = 1'b1; blk_done = 1'b1;
        tick;
        blk_err = 1'b0; blk_done = 1'b0;
        chk("D idle after err", {30'b0, dbg_state}, 32'(ST_IDLE));
        status_chk("D err wins", 32'd3);
        rw(30'd0, 32'd1);
        status_chk("D cleared", 32'd1);

        // RESET together with a short-block done: reset wins, no error
        start_read(32'd9, "R");
        stream(50, 1'b1, 1'b1, 32'd0);
        blk_done = 1'b1;
        rw(30'd0, 32'd1);
        blk_done = 1'b0;
        chk("R reset status", s_data_o, 32'd2);
        status_chk("R reset wins", 32'd1);

        // RESET aborts a pending request
        rw(30'(CMD_READ), 32'd12);
        chk("abort req up", {31'b0, blk_req}, 32'd1);
        rw(30'd0, 32'd1);
        chk("abort status", s_data_o, 32'd2);
        chk("abort req down", {31'b0, blk_req}, 32'd0);
        status_chk("abort ready", 32'd1);

        // PHY drops during REQ: back to idle without error
        rw(30'(CMD_READ), 32'd10);
        chk("E req", {31'b0, blk_req}, 32'd1);
        phy_ready = 1'b0;
        tick;
        chk("E req dropped", {31'b0, blk_req}, 32'd0);
        status_chk("E poweroff", 32'd0);
        phy_ready = 1'b1;
        status_chk("E ready no err", 32'd1);

`ifdef BLKDEV_CTRL_WRITE_EN
        begin
            int beats, cyc;
            logic ph;
            fill_front;
            rw(30'(CMD_SWAP), 32'd0);
            bank_m = ~bank_m;
            exp_q.delete();
            for (int i = 0; i < BLKW; i++) exp_q.push_back(mem_m[!bank_m][i]);
            rw(30'(CMD_WRITE), 32'd9);
            chk("W cmd status", s_data_o, 32'd1);
            chk("W req", {31'b0, blk_req}, 32'd1);
            chk("W wr", {31'b0, blk_wr}, 32'd1);
            chk("W addr", blk_addr, 32'd9);
            blk_ack = 1'b1;
            tick;
            blk_ack = 1'b0;
            beats = 0; cyc = 0; ph = 1'b0;
            while (beats < BLKW && cyc < 600) begin
                blk_wready = ph;
                ph = ~ph;
                if (blk_wvalid && blk_wready) begin
                    chk($sformatf("W word %0d", beats), blk_wdata, exp_q.pop_front());
                    beats++;
                end
                tick;
                cyc++;
            end
            blk_wready = 1'b0;
            chk("W beat count", 32'(beats), 32'd128);
            chk("W wvalid low at end", {31'b0, blk_wvalid}, 32'd0);
            pulse_done;
            status_chk("W ready", 32'd1);
        end
`else
        rw(30'(CMD_WRITE), 32'd9);
        chk("W status only", s_data_o, 32'd1);
        chk("W no req", {31'b0, blk_req}, 32'd0);
        chk("W wr tied", {31'b0, blk_wr}, 32'd0);
        chk("W wvalid tied", {31'b0, blk_wvalid}, 32'd0);
        status_chk("W still ready", 32'd1);
`endif

        // Asynchronous reset mid-transfer
        start_read(32'd11, "G");
        stream(10, 1'b0, 1'b1, 32'd0);
        status_chk("G busy", 32'd2);
        #3;
        rst_i = 1'b0;
        #1;
        chk("G async data_o", s_data_o, 32'd0);
        chk("G async rdy", {31'b0, s_rdy}, 32'd0);
        chk("G async req", {31'b0, blk_req}, 32'd0);
        chk("G async blk_addr", blk_addr, 32'd0);
        chk("G async wr", {31'b0, blk_wr}, 32'd0);
        chk("G async wvalid", {31'b0, blk_wvalid}, 32'd0);
        chk("G async wdata", blk_wdata, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        bank_m = 1'b0;
        tick;
        chk("G rdy after release", {31'b0, s_rdy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("G no req after release", {31'b0, blk_req}, 32'd0);
        end
        status_chk("G ready", 32'd1);

        // Randomized traffic against the buffer model
        fill_front;
        rw(30'(CMD_SWAP), 32'd0);
        bank_m = ~bank_m;
        fill_front;
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [29:0] a;
            logic [31:0] d;
            k = $urandom_range(0, 9);
            a = 30'($urandom);
            if (k <= 3) begin
                wr(a, $urandom, 4'($urandom_range(0, 15)));
            end else if (k <= 6) begin
                rd_model("H rd", a);
            end else if (k == 7) begin
                rw(30'(CMD_SWAP), 32'd0);
                chk("H swap status", s_data_o, 32'd1);
                bank_m = ~bank_m;
            end else if (k == 8) begin
                rw(30'($urandom_range(4, 1000)), $urandom);
                chk("H other cmd", s_data_o, 32'd1);
            end else begin
                d = 32'($urandom_range(0, 1));
                rw(30'd0, d);
                chk("H reset cmd", s_data_o, 32'd1);
                if (d == 32'd1) bank_m = 1'b0;
            end
            if ((n % 100) == 50) begin
                start_read($urandom, "H");
                stream(BLKW + $urandom_range(0, 2), 1'b1, 1'b1, 32'd0);
                pulse_done;
                status_chk("H block ready", 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
